// File: rtl/mm_fetch_pkg.sv
// Shared types and default sizes for the two-requester Avalon-MM fetch arbiter.
package mm_fetch_pkg;

  localparam int ADDR_W_DEF      = 12;
  localparam int DATA_W_DEF      = 8;
  localparam int LEN_W_DEF       = 12;
  localparam int MAX_PENDING_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

  typedef enum logic {
    REQ_IMAGE = 1'b0,
    REQ_COEFF = 1'b1
  } req_id_e;

endpackage

// File: rtl/mm_fetch_grant.sv
// Picks which pending requester is served next. Define MM_FETCH_ARB_RR_EN for
// round-robin on ties; otherwise the image loader (requester 0) always wins.
module mm_fetch_grant
  import mm_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] pend,
  input  logic       take,
  output logic       grant_valid,
  output req_id_e    grant_id
);

  assign grant_valid = |pend;

`ifdef MM_FETCH_ARB_RR_EN
  req_id_e last_q, last_d;

  // The tie pointer only moves when a tie is actually arbitrated, so a lone
  // request never disturbs the alternation between simultaneous requests.
  always_comb begin
    grant_id = pend[0] ? REQ_IMAGE : REQ_COEFF;
    if (&pend) grant_id = (last_q == REQ_IMAGE) ? REQ_COEFF : REQ_IMAGE;
    last_d = last_q;
    if (take && (&pend)) last_d = grant_id;
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= REQ_COEFF;
    else       last_q <= last_d;
  end
`else
  logic unused_ok;
  assign unused_ok = ^{clk, reset, take};
  assign grant_id  = pend[0] ? REQ_IMAGE : REQ_COEFF;
`endif

endmodule

// File: rtl/mm_fetch_arbiter.sv
// Two-requester single-beat Avalon-MM read fetcher with bounded pending reads.
// Arbitration policy is selected by MM_FETCH_ARB_RR_EN (see mm_fetch_grant).
module mm_fetch_arbiter
  import mm_fetch_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int LEN_W       = LEN_W_DEF,
  parameter int MAX_PENDING = MAX_PENDING_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             rq_start,
  input  logic [1:0][ADDR_W-1:0] rq_addr,
  input  logic [1:0][LEN_W-1:0]  rq_len,
  output logic [1:0]             rq_busy,
  output logic [1:0]             rq_done,
  output logic [DATA_W-1:0]      rq_data,
  output logic [1:0]             rq_data_valid,
  output logic [ADDR_W-1:0]      avm_address,
  output logic                   avm_read,
  output logic                   avm_burstcount,
  input  logic                   avm_waitrequest,
  input  logic [DATA_W-1:0]      avm_readdata,
  input  logic                   avm_readdatavalid
);

  localparam int OUT_W = $clog2(MAX_PENDING + 1);

  state_e                  state_q, state_d;
  req_id_e                 grant_q, grant_d;
  logic [1:0]              busy_q, busy_d, pend_q, pend_d, done_q, done_d;
  logic [1:0][ADDR_W-1:0]  base_q, base_d;
  logic [1:0][LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]        cnt_q, cnt_d;
  logic [OUT_W-1:0]        outst_q, outst_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic                    read_q, read_d;
  logic                    accept, ret, take, gnt_valid;
  req_id_e                 gnt_id;

  assign accept = read_q & ~avm_waitrequest;
  // Returns with nothing outstanding belong to reads killed by reset.
  assign ret    = avm_readdatavalid & (outst_q != '0);
  assign take   = (state_q == IDLE) & gnt_valid;

  mm_fetch_grant u_grant (
    .clk         (clk),
    .reset       (reset),
    .pend        (pend_q),
    .take        (take),
    .grant_valid (gnt_valid),
    .grant_id    (gnt_id)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    pend_d  = pend_q;
    done_d  = '0;
    base_d  = base_q;
    len_d   = len_q;
    cnt_d   = accept ? cnt_q + LEN_W'(1) : cnt_q;
    addr_d  = addr_q;
    read_d  = read_q;
    outst_d = outst_q + OUT_W'(accept) - OUT_W'(ret);

    case (state_q)
      IDLE: if (gnt_valid) begin
        grant_d        = gnt_id;
        pend_d[gnt_id] = 1'b0;
        cnt_d          = '0;
        if (len_q[gnt_id] == '0) begin
          state_d        = DONE;
          done_d[gnt_id] = 1'b1;
        end else begin
          state_d = ISSUE;
          read_d  = 1'b1;
          addr_d  = base_q[gnt_id];
        end
      end
      ISSUE: begin
        if (accept && (cnt_d == len_q[grant_q])) begin
          read_d  = 1'b0;
          state_d = DRAIN;
        end else if (!read_q || accept) begin
          // A stalled read (waitrequest) falls through here and holds.
          read_d = (outst_d < OUT_W'(MAX_PENDING));
          addr_d = base_q[grant_q] + ADDR_W'(cnt_d);
        end
      end
      DRAIN: if (outst_d == '0) begin
        state_d         = DONE;
        done_d[grant_q] = 1'b1;
      end
      DONE: begin
        busy_d[grant_q] = 1'b0;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase

    for (int i = 0; i < 2; i++) begin
      if (rq_start[i] && !busy_q[i]) begin
        busy_d[i] = 1'b1;
        pend_d[i] = 1'b1;
        base_d[i] = rq_addr[i];
        len_d[i]  = rq_len[i];
      end
    end
  end

  // NOTE: the per-requester address/length registers are only two entries,
  // so they are reset with everything else to keep outputs X-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= REQ_IMAGE;
      busy_q  <= '0;
      pend_q  <= '0;
      done_q  <= '0;
      base_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      outst_q <= '0;
      addr_q  <= '0;
      read_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      base_q  <= base_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      outst_q <= outst_d;
      addr_q  <= addr_d;
      read_q  <= read_d;
    end
  end

  assign avm_address    = addr_q;
  assign avm_read       = read_q;
  assign avm_burstcount = 1'b1;
  assign rq_busy        = busy_q;
  assign rq_done        = done_q;
  assign rq_data_valid  = ret ? ((grant_q == REQ_IMAGE) ? 2'b01 : 2'b10) : 2'b00;
  assign rq_data        = ret ? avm_readdata : '0;

endmodule

// File: tb/tb_mm_fetch_arbiter.sv
// Self-checking bench: Avalon slave model with random stalls/latency and an
// address/owner scoreboard derived from the transfer descriptions.
module tb_mm_fetch_arbiter;
  import mm_fetch_pkg::*;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int LW = 12;
  localparam int MP = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [1:0]          rq_start;
  logic [1:0][AW-1:0]  rq_addr;
  logic [1:0][LW-1:0]  rq_len;
  logic [1:0]          rq_busy, rq_done, rq_data_valid;
  logic [DW-1:0]       rq_data;
  logic [AW-1:0]       avm_address;
  logic                avm_read, avm_burstcount;
  logic                avm_waitrequest, avm_readdatavalid;
  logic [DW-1:0]       avm_readdata;

  always #5 clk = ~clk;

  mm_fetch_arbiter dut (
    .clk               (clk),
    .reset             (reset),
    .rq_start          (rq_start),
    .rq_addr           (rq_addr),
    .rq_len            (rq_len),
    .rq_busy           (rq_busy),
    .rq_done           (rq_done),
    .rq_data           (rq_data),
    .rq_data_valid     (rq_data_valid),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_burstcount    (avm_burstcount),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid)
  );

  typedef struct { logic [AW-1:0] addr; int due; bit stale; } rd_t;
  typedef struct { int owner; logic [AW-1:0] addr; } exp_t;

  rd_t  inflight[$];
  exp_t exp_acc[$];
  exp_t exp_ret[$];
  int   done_exp[$];

  int n_tests = 0, n_fail = 0;
  int cyc = 0, lat = 0, wr_pct = 0, model_out = 0, max_out = 0;
  int start_cyc, first_read_cyc = -1, last_ret_cyc = 0, last_done_cyc = 0;
  bit prev_read = 1'b0, prev_wr = 1'b0, acc_this_step = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    return a[7:0] ^ {4'h0, a[11:8]} ^ 8'h5A;
  endfunction

  // Expected service: len reads at base, base+1, ... modulo 2^AW, then a done.
  task automatic push_xfer(input int owner, input logic [AW-1:0] base, input int len);
    exp_t e;
    for (int i = 0; i < len; i++) begin
      e.owner = owner;
      e.addr  = AW'(int'(base) + i);
      exp_acc.push_back(e);
    end
    done_exp.push_back(owner);
  endtask

  // One clock: checks at the falling edge, then drives slave inputs for the next rising edge.
  task automatic step();
    rd_t  r;
    exp_t e;
    @(negedge clk);
    cyc++;
    acc_this_step = 1'b0;
    if (prev_read && prev_wr) begin
      check("hold_read", 32'(avm_read), 1);
      check("hold_addr", 32'(avm_address), 32'(prev_addr));
    end
    if (avm_read) begin
      check("max_pending", 32'(model_out < MP), 1);
      if (first_read_cyc < 0) first_read_cyc = cyc;
    end
    if (model_out > max_out) max_out = model_out;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    if (inflight.size() != 0 && inflight[0].due <= cyc) begin
      r = inflight.pop_front();
      avm_readdatavalid = 1'b1;
      avm_readdata      = mem(r.addr);
      #1;
      if (r.stale) begin
        check("stale_valid", 32'(rq_data_valid), 0);
        check("stale_data", 32'(rq_data), 0);
      end else begin
        e = exp_ret.pop_front();
        model_out--;
        check("ret_valid", 32'(rq_data_valid), 32'(1 << e.owner));
        check("ret_data", 32'(rq_data), 32'(mem(e.addr)));
        last_ret_cyc = cyc;
      end
    end else begin
      #1;
      check("no_ret_valid", 32'(rq_data_valid), 0);
    end
    prev_wr = (wr_pct != 0) && ($urandom_range(99) < wr_pct);
    avm_waitrequest = prev_wr;
    if (avm_read && !prev_wr) begin
      acc_this_step = 1'b1;
      check("read_expected", 32'(exp_acc.size() != 0), 1);
      if (exp_acc.size() != 0) begin
        e = exp_acc.pop_front();
        check("acc_addr", 32'(avm_address), 32'(e.addr));
        exp_ret.push_back(e);
        model_out++;
        inflight.push_back('{avm_address, cyc + 1 + lat, 1'b0});
      end else begin
        inflight.push_back('{avm_address, cyc + 1 + lat, 1'b1});
      end
    end
    if (rq_done != 2'b00) begin
      check("done_expected", 32'(done_exp.size() != 0), 1);
      if (done_exp.size() != 0) check("done_owner", 32'(rq_done), 32'(1 << done_exp.pop_front()));
      last_done_cyc = cyc;
    end
    prev_read = avm_read;
    prev_addr = avm_address;
  endtask

  task automatic start(input logic [1:0] which, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [LW-1:0] l0, input logic [LW-1:0] l1);
    rq_start   = which;
    rq_addr[0] = a0;
    rq_addr[1] = a1;
    rq_len[0]  = l0;
    rq_len[1]  = l1;
    start_cyc      = cyc;
    first_read_cyc = -1;
    step();
    rq_start = 2'b00;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(exp_acc.size() == 0 && exp_ret.size() == 0 && inflight.size() == 0 &&
             done_exp.size() == 0 && rq_busy == 2'b00) && n < 400) begin
      step();
      n++;
    end
    check(tag, 32'(exp_acc.size() + exp_ret.size() + inflight.size() + done_exp.size()), 0);
    check({tag, "_busy"}, 32'(rq_busy), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_read"}, 32'(avm_read), 0);
    check({tag, "_addr"}, 32'(avm_address), 0);
    check({tag, "_busy"}, 32'(rq_busy), 0);
    check({tag, "_done"}, 32'(rq_done), 0);
    check({tag, "_dv"}, 32'(rq_data_valid), 0);
    check({tag, "_data"}, 32'(rq_data), 0);
    check({tag, "_burst"}, 32'(avm_burstcount), 1);
  endtask

  initial begin
    logic [AW-1:0] b0, b1;
    int n;
    reset = 1'b1;
    rq_start = '0; rq_addr = '0; rq_len = '0;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
    repeat (3) step();
    check_reset_outputs("rst");
    reset = 1'b0;
    step();

    // Image fetch, no stalls, minimum latency: latency, busy, done timing.
    lat = 0; wr_pct = 0;
    push_xfer(0, 12'h010, 4);
    start(2'b01, 12'h010, 12'h000, 12'd4, 12'd0);
    check("busy_set", 32'(rq_busy), 32'b01);
    wait_idle("img4");
    check("start_to_read", 32'(first_read_cyc - start_cyc), 2);
    check("done_after_last_ret", 32'(last_done_cyc - last_ret_cyc), 1);

    // Coefficient fetch across the address wrap.
    push_xfer(1, 12'hFFE, 4);
    start(2'b10, 12'h000, 12'hFFE, 12'd0, 12'd4);
    wait_idle("coef_wrap");

    // Long latency with random stalls; a start while busy must be ignored.
    lat = 10; wr_pct = 20; max_out = 0;
    b0 = AW'($urandom);
    push_xfer(0, b0, 8);
    start(2'b01, b0, 12'h000, 12'd8, 12'd0);
    repeat (3) step();
    rq_start = 2'b01; rq_addr[0] = b0 + 12'h100; rq_len[0] = 12'd3;
    step();
    rq_start = 2'b00;
    wait_idle("lat10");
    check("max_out_reached", 32'(max_out), MP);

    // Two simultaneous starts, twice.
    lat = int'($urandom_range(3)); wr_pct = 0;
    for (int t = 0; t < 2; t++) begin
      b0 = AW'($urandom);
      b1 = AW'($urandom);
`ifdef MM_FETCH_ARB_RR_EN
      if (t == 0) begin push_xfer(0, b0, 2); push_xfer(1, b1, 2); end
      else        begin push_xfer(1, b1, 2); push_xfer(0, b0, 2); end
`else
      push_xfer(0, b0, 2); push_xfer(1, b1, 2);
`endif
      start(2'b11, b0, b1, 12'd2, 12'd2);
      check("tie_busy", 32'(rq_busy), 32'b11);
      wait_idle("tie");
    end

    // Zero-length transfers: no reads, done still pulses.
    push_xfer(0, 12'h123, 0);
    start(2'b01, 12'h123, 12'h000, 12'd0, 12'd0);
    wait_idle("len0_img");
    push_xfer(1, 12'h456, 0);
    start(2'b10, 12'h000, 12'h456, 12'd0, 12'd0);
    wait_idle("len0_coef");

    // Reset with three reads outstanding, then stale returns, then a clean transfer.
    lat = 8; wr_pct = 0;
    b0 = AW'($urandom);
    push_xfer(0, b0, 8);
    start(2'b01, b0, 12'h000, 12'd8, 12'd0);
    n = 0;
    while (model_out < 4 && n < 40) begin step(); n++; end
    reset = 1'b1;
    // The read decided this cycle never reaches its rising edge.
    if (acc_this_step) void'(inflight.pop_back());
    check("outst_before_reset", 32'(inflight.size()), 3);
    foreach (inflight[i]) inflight[i].stale = 1'b1;
    exp_acc.delete(); exp_ret.delete(); done_exp.delete();
    model_out = 0; prev_read = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    step(); step();
    reset = 1'b0;
    n = 0;
    while (inflight.size() != 0 && n < 40) begin step(); n++; end
    check("stale_drained", 32'(inflight.size()), 0);
    lat = 1;
    b1 = AW'($urandom);
    push_xfer(1, b1, 3);
    start(2'b10, 12'h000, b1, 12'd0, 12'd3);
    wait_idle("after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mm_fetch_arbiter.md
MM_FETCH_ARBITER -- requirements
Module: mm_fetch_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, Avalon-MM byte address width.
REQ-002 SHALL have parameter DATA_W, default 8, read data width.
REQ-003 SHALL have parameter LEN_W, default 12, transfer length width in beats.
REQ-004 SHALL have parameter MAX_PENDING, default 4, maximum reads accepted but not yet returned.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port rq_start, input, [1:0], per-requester start pulse (0 = image loader, 1 = coefficient loader).
REQ-008 SHALL have port rq_addr, input, [1:0][ADDR_W], per-requester base address, sampled with rq_start.
REQ-009 SHALL have port rq_len, input, [1:0][LEN_W], per-requester beat count, sampled with rq_start.
REQ-010 SHALL have port rq_busy, output, [1:0], requester has a captured or active transfer.
REQ-011 SHALL have port rq_done, output, [1:0], one-cycle completion pulse.
REQ-012 SHALL have port rq_data, output, DATA_W, returned read data, shared by both requesters.
REQ-013 SHALL have port rq_data_valid, output, [1:0], rq_data belongs to the flagged requester this cycle.
REQ-014 SHALL have Avalon-MM master ports: avm_address out ADDR_W; avm_read out 1; avm_burstcount out 1, tied to 1; avm_waitrequest in 1; avm_readdata in DATA_W; avm_readdatavalid in 1.

Function
REQ-015 SHALL capture rq_start[i] with rq_addr[i]/rq_len[i] only when rq_busy[i]=0; a start while busy SHALL be ignored.
REQ-016 SHALL use FSM states IDLE, ISSUE, DRAIN, DONE.
- IDLE: if any captured request, grant one per REQ-030/031 -> ISSUE (rq_len=0 -> DONE).
- ISSUE: last read accepted -> DRAIN.
- DRAIN: outstanding=0 -> DONE.
- DONE: pulse rq_done[grant], clear rq_busy[grant] -> IDLE.
REQ-017 SHALL assert avm_read first in the cycle after the edge that enters ISSUE; start-to-first-read latency SHALL be 2 edges when the arbiter is idle.
REQ-018 SHALL hold avm_address and avm_read stable while avm_waitrequest=1; a read is accepted on a cycle with avm_read=1 and avm_waitrequest=0.
REQ-019 SHALL drive avm_address = base + accepted_count, modulo 2^ADDR_W (wrap, no error).
REQ-020 SHALL not assert avm_read while outstanding = MAX_PENDING.
REQ-021 SHALL increment outstanding on accept and decrement on avm_readdatavalid; both in one cycle leave it unchanged.
REQ-022 SHALL forward avm_readdata to rq_data and assert rq_data_valid[grant] in the same cycle as avm_readdatavalid, combinationally and with zero latency.
REQ-023 SHALL ignore avm_readdatavalid when outstanding = 0.
REQ-024 SHALL set rq_busy[i] in the cycle after rq_start[i] is captured and clear it in the cycle after rq_done[i].
REQ-025 SHALL allow both requesters to start in the same cycle; both SHALL be captured.

Reset
REQ-026 SHALL, on reset, force state IDLE, outstanding 0, clear captured requests, and drop any in-flight transfer without a done pulse.
REQ-027 SHALL reset outputs: avm_read 0, avm_address 0, rq_busy 0, rq_done 0, rq_data_valid 0, rq_data 0.
REQ-028 SHALL ignore avm_readdatavalid returns that belong to reads issued before reset.

Configuration
REQ-029 SHALL use macro MM_FETCH_ARB_RR_EN to select the arbitration policy.
REQ-030 SHALL, with MM_FETCH_ARB_RR_EN defined, grant round-robin: on simultaneous pending requests, grant the requester not granted last (requester 0 first after reset).
REQ-031 SHALL, without MM_FETCH_ARB_RR_EN, use fixed priority: requester 0 always wins a tie.

Structure
REQ-032 SHALL place ADDR_W/DATA_W/LEN_W defaults, MAX_PENDING, the state enum and the requester-ID enum (REQ_IMAGE=0, REQ_COEFF=1) in package mm_fetch_pkg.
REQ-033 SHALL implement grant selection in sub-module mm_fetch_grant, which holds all MM_FETCH_ARB_RR_EN conditional logic.

Verification
REQ-034 Image start with addr=0x010, len=4, waitrequest=0, latency 0 -> reads at 0x010..0x013; 4 rq_data_valid[0]; rq_done[0] one cycle after the 4th return.
REQ-035 Coefficient start with addr=0xFFE, len=4 -> addresses 0xFFE, 0xFFF, 0x000, 0x001.
REQ-036 len=8, return latency 10 -> never more than 4 reads outstanding; avm_address held during 2 random waitrequest cycles.
REQ-037 Both starts in one cycle, len=2 each -> RR build serves 0 then 1, and a second tie serves 1 first; non-RR build serves 0 first on both ties.
REQ-038 len=0 -> no avm_read; rq_done pulses; rq_busy clears.
REQ-039 Reset asserted with 3 reads outstanding -> all outputs at reset values; late readdatavalid produces no rq_data_valid; a new start afterwards completes normally.
